// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if -- every signal that passes between the tile scheduler
// and its environment, apart from clk and rst.
//
// Ports (the master side is the scheduler):
//   job side : start, num_tiles        -> scheduler
//              busy, done, err, tile_idx <- scheduler
//   array    : ctl_start, tile_base    <- scheduler
//              ctl_done                -> scheduler
//   result   : res_sel, wr_req, wr_addr <- scheduler
//              mem_gnt                 -> scheduler
interface tile_scheduler_if #(
  parameter int ADD_WIDTH = 6,
  parameter int ROW       = 4,
  parameter int COL       = 4,
  parameter int TILE_W    = 4
);
  localparam int SEL_W = $clog2(ROW * COL);

  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              busy;
  logic              done;
  logic              err;
  logic [TILE_W-1:0] tile_idx;

  logic              ctl_start;
  logic              ctl_done;
  logic [ADD_WIDTH:0] tile_base;

  logic [SEL_W-1:0]  res_sel;
  logic              wr_req;
  logic              mem_gnt;
  logic [ADD_WIDTH:0] wr_addr;

  modport master (
    input  start, num_tiles, ctl_done, mem_gnt,
    output busy, done, err, tile_idx, ctl_start, tile_base, res_sel, wr_req, wr_addr
  );

  modport slave (
    output start, num_tiles, ctl_done, mem_gnt,
    input  busy, done, err, tile_idx, ctl_start, tile_base, res_sel, wr_req, wr_addr
  );
endinterface

// File: rtl/tile_scheduler.sv
// tile_scheduler -- sequences a job of num_tiles tiles through a ROW x COL
// compute array: launches the array controller for each tile, waits for
// completion, then drains ROW*COL results into the shared result RAM through
// a granted write port, and pulses done once the whole job is finished.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : tile_scheduler_if.master (start/num_tiles/busy/done/err/tile_idx,
//          ctl_start/ctl_done/tile_base, res_sel/wr_req/mem_gnt/wr_addr)
//
// Build option: define TILE_SCHED_TIMEOUT_EN to enable the WAIT-state
// watchdog. After 255 WAIT cycles without ctl_done the job is abandoned and
// the sticky err flag is raised. Without the macro err is constant 0 and WAIT
// waits forever.
module tile_scheduler #(
  parameter int ADD_WIDTH = 6,
  parameter int ROW       = 4,
  parameter int COL       = 4,
  parameter int TILE_W    = 4,
  parameter int RES_BASE  = 64
) (
  input  logic              clk,
  input  logic              rst,
  tile_scheduler_if.master  bus
);

  localparam int AW    = ADD_WIDTH + 1;
  localparam int SEL_W = $clog2(ROW * COL);

  localparam logic [AW-1:0]    TILE_STRIDE = AW'(2 * ROW * COL);
  localparam logic [AW-1:0]    RES_STRIDE  = AW'(ROW * COL);
  localparam logic [AW-1:0]    RES_BASE_A  = AW'(RES_BASE);
  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(ROW * COL - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DRAIN,
    NEXT,
    FIN
  } state_t;

  state_t            state;
  logic [TILE_W-1:0] count_q;
  logic [TILE_W-1:0] tile_idx_q;
  logic [TILE_W-1:0] next_idx;
  logic [SEL_W-1:0]  res_sel_q;
  logic              ctl_start_q;
  logic              wr_req_q;
  logic              busy_q;
  logic              done_q;

`ifdef TILE_SCHED_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'd254;
  logic [7:0] wdog_q;
  logic       err_q;
`endif

  assign next_idx = tile_idx_q + TILE_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count_q     <= '0;
      tile_idx_q  <= '0;
      res_sel_q   <= '0;
      ctl_start_q <= 1'b0;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // ctl_start and done are single-cycle pulses; only the transitions
      // below raise them.
      ctl_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            count_q    <= bus.num_tiles;
            tile_idx_q <= '0;
            res_sel_q  <= '0;
            busy_q     <= 1'b1;
`ifdef TILE_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            if (bus.num_tiles == '0) begin
              state <= FIN;
            end else begin
              state       <= LAUNCH;
              ctl_start_q <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef TILE_SCHED_TIMEOUT_EN
          wdog_q <= '0;
`endif
        end
        WAIT: begin
          if (bus.ctl_done) begin
            state    <= DRAIN;
            wr_req_q <= 1'b1;
          end
`ifdef TILE_SCHED_TIMEOUT_EN
          // wdog_q counts completed WAIT cycles; 254 means this is the 255th.
          else if (wdog_q == WDOG_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
`endif
        end
        DRAIN: begin
          if (bus.mem_gnt) begin
            if (res_sel_q == LAST_SEL) begin
              res_sel_q <= '0;
              wr_req_q  <= 1'b0;
              state     <= NEXT;
            end else begin
              res_sel_q <= res_sel_q + SEL_W'(1);
            end
          end
        end
        NEXT: begin
          tile_idx_q <= next_idx;
          if (next_idx == count_q) begin
            state <= FIN;
          end else begin
            state       <= LAUNCH;
            ctl_start_q <= 1'b1;
          end
        end
        FIN: begin
          // done appears in the cycle after FIN, i.e. two cycles after the
          // accepting start edge for an empty job.
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctl_start = ctl_start_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tile_idx  = tile_idx_q;
  assign bus.res_sel   = res_sel_q;

  // Address arithmetic is done at AW bits so it wraps naturally.
  assign bus.tile_base = AW'(tile_idx_q) * TILE_STRIDE;

  // wr_addr is only meaningful while a write is requested; gating it keeps
  // the output at zero in reset and idle.
  assign bus.wr_addr = wr_req_q
                     ? (RES_BASE_A + AW'(tile_idx_q) * RES_STRIDE + AW'(res_sel_q))
                     : '0;

`ifdef TILE_SCHED_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler -- scoreboard bench for tile_scheduler. Stimulus pushes
// expected launches, per-cycle drain values and done pulses into queues; a
// negedge monitor pops and compares whenever the DUT presents one of them.
module tb_tile_scheduler;
  localparam int ADD_WIDTH = 6;
  localparam int ROW       = 4;
  localparam int COL       = 4;
  localparam int TILE_W    = 4;

  typedef struct {
    int addr;
    int sel;
  } drain_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tile_scheduler_if #(
    .ADD_WIDTH(ADD_WIDTH), .ROW(ROW), .COL(COL), .TILE_W(TILE_W)
  ) bus ();

  tile_scheduler #(
    .ADD_WIDTH(ADD_WIDTH), .ROW(ROW), .COL(COL), .TILE_W(TILE_W), .RES_BASE(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     done_seen = 0;
  int     exp_launch[$];
  drain_t exp_drain[$];
  int     exp_done[$];

  bit     gnt_toggle = 1'b0;
  int     gnt_k      = 0;
  bit     respond    = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT event with no expected entry queued (t=%0t)", name, $time);
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_ctl_start"}, 32'(bus.ctl_start), 0);
    check({tag, "_wr_req"},    32'(bus.wr_req),    0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
    check({tag, "_err"},       32'(bus.err),       0);
    check({tag, "_tile_idx"},  32'(bus.tile_idx),  0);
    check({tag, "_res_sel"},   32'(bus.res_sel),   0);
    check({tag, "_tile_base"}, 32'(bus.tile_base), 0);
    check({tag, "_wr_addr"},   32'(bus.wr_addr),   0);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the
  // edge that sampled start.
  task automatic do_start(input int n);
    bus.start     = 1'b1;
    bus.num_tiles = TILE_W'(n);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.num_tiles = '1;
  endtask

  task automatic wait_done(input string name, input int limit);
    int c0;
    int i;
    c0 = done_seen;
    i  = 0;
    while (done_seen == c0 && i < limit) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(name, 32'(done_seen != c0), 1);
  endtask

  task automatic push_tile(input int t);
    for (int i = 0; i < ROW * COL; i++) exp_drain.push_back('{64 + 16 * t + i, i});
  endtask

  // Array controller model: ctl_done rises 5 cycles after ctl_start.
  initial begin
    bus.ctl_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ctl_start && respond) begin
        repeat (5) @(posedge clk);
        #1;
        bus.ctl_done = 1'b1;
        @(posedge clk);
        #1;
        bus.ctl_done = 1'b0;
      end
    end
  end

  // Write-port arbiter model: always grant, or alternate 0,1,0,1 over the
  // DRAIN cycles.
  initial begin
    bus.mem_gnt = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gnt_toggle) begin
        if (bus.wr_req) begin
          bus.mem_gnt = gnt_k[0];
          gnt_k++;
        end else begin
          bus.mem_gnt = 1'b0;
        end
      end else begin
        bus.mem_gnt = 1'b1;
      end
    end
  end

  // Monitor
  int     m_exp;
  drain_t m_d;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ctl_start || bus.wr_req || bus.done)
        check("exclusive_pulses", 32'(int'(bus.ctl_start) + int'(bus.wr_req) + int'(bus.done)), 1);
      if (bus.ctl_start) begin
        if (exp_launch.size() == 0) unexpected("ctl_start");
        else begin
          m_exp = exp_launch.pop_front();
          check("tile_base", 32'(bus.tile_base), m_exp);
        end
      end
      if (bus.wr_req) begin
        if (exp_drain.size() == 0) unexpected("wr_req");
        else begin
          m_d = exp_drain.pop_front();
          check("wr_addr", 32'(bus.wr_addr), m_d.addr);
          check("res_sel", 32'(bus.res_sel), m_d.sel);
        end
      end
      if (bus.done) begin
        done_seen++;
        if (exp_done.size() == 0) unexpected("done");
        else begin
          m_exp = exp_done.pop_front();
          check("done_tile_idx", 32'(bus.tile_idx), m_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int i;
    bus.start     = 1'b0;
    bus.num_tiles = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    zero_check("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // One tile, continuous grant
    exp_launch.push_back(0);
    push_tile(0);
    exp_done.push_back(1);
    do_start(1);
    check("busy_after_start", 32'(bus.busy), 1);
    check("ctl_start_after_start", 32'(bus.ctl_start), 1);
    wait_done("done_one_tile", 500);
    check("tile_idx_hold", 32'(bus.tile_idx), 1);
    check("busy_idle", 32'(bus.busy), 0);

    // Three tiles; start held while busy must be ignored
    exp_launch.push_back(0);
    exp_launch.push_back(32);
    exp_launch.push_back(64);
    for (int t = 0; t < 3; t++) push_tile(t);
    exp_done.push_back(3);
    do_start(3);
    bus.start     = 1'b1;
    bus.num_tiles = TILE_W'(5);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("done_three_tiles", 1000);

    // Grant alternating 0,1 over DRAIN: 32 drain cycles for 16 writes
    gnt_k      = 0;
    gnt_toggle = 1'b1;
    exp_launch.push_back(0);
    for (int j = 0; j < 32; j++) exp_drain.push_back('{64 + j / 2, j / 2});
    exp_done.push_back(1);
    do_start(1);
    wait_done("done_gnt_toggle", 500);
    gnt_toggle = 1'b0;

    // Empty job: done two cycles after start is sampled
    exp_done.push_back(0);
    do_start(0);
    @(negedge clk);
    check("zero_job_c1_done", 32'(bus.done), 0);
    check("zero_job_c1_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("zero_job_c2_done", 32'(bus.done), 1);
    @(posedge clk);
    #1;

    // Asynchronous reset in DRAIN at res_sel=7
    exp_launch.push_back(0);
    for (int k = 0; k < 7; k++) exp_drain.push_back('{64 + k, k});
    do_start(1);
    i = 0;
    while (!(bus.wr_req && bus.res_sel == 7) && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("reach_res_sel_7", 32'(bus.wr_req && bus.res_sel == 7), 1);
    rst = 1'b0;
    #1;
    zero_check("async_reset");
    @(posedge clk);
    #1;
    zero_check("reset_hold");
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_busy", 32'(bus.busy), 0);
    exp_launch.push_back(0);
    push_tile(0);
    exp_done.push_back(1);
    do_start(1);
    check("restart_tile_idx", 32'(bus.tile_idx), 0);
    check("restart_res_sel", 32'(bus.res_sel), 0);
    wait_done("done_after_abort", 500);

`ifdef TILE_SCHED_TIMEOUT_EN
    // Watchdog: no ctl_done for 255 WAIT cycles
    respond = 1'b0;
    exp_launch.push_back(0);
    do_start(2);
    repeat (255) @(posedge clk);
    #1;
    check("wdog_before_err", 32'(bus.err), 0);
    check("wdog_before_busy", 32'(bus.busy), 1);
    @(posedge clk);
    #1;
    check("wdog_err", 32'(bus.err), 1);
    check("wdog_busy", 32'(bus.busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check("wdog_err_sticky", 32'(bus.err), 1);
    respond = 1'b1;
    exp_launch.push_back(0);
    push_tile(0);
    exp_done.push_back(1);
    do_start(1);
    check("wdog_err_cleared", 32'(bus.err), 0);
    wait_done("done_after_wdog", 500);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("launch_queue_empty", 32'(exp_launch.size()), 0);
    check("drain_queue_empty",  32'(exp_drain.size()),  0);
    check("done_queue_empty",   32'(exp_done.size()),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
